mux4_rr_arbiter: RTL and testbench

Sequential controller that shares the 4-to-1 bit multiplexer datapath among four requesters using round-robin arbitration. It owns the two select lines: the high bit picks the pair, the low bit picks within the pair. It registers the selected data bit to a single output. It sits between the switch or requester logic and the LED or output stage, replacing hand-driven select switches with a granted, time-shared select.

---
 rtl/mux4_rr_arbiter.sv | 117 +++++++++++
 tb/tb_mux4_rr_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that time-shares a 4:1 bit mux among four requesters and registers the selected bit.
// Optional forced release after MAX_HOLD grant cycles is enabled by defining MUXARB_TIMEOUT_EN.
module mux4_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [3:0] req,
    input  logic [3:0] data_in,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       busy,
    output logic       data_out
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] last_q, last_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] gnt_q, gnt_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       data_out_q, data_out_d;

    logic [3:0] rot_req;
    logic [1:0] offset;
    logic [1:0] winner;
    logic       timeout;

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("MAX_HOLD must be in 1..255");
    end

    // rot_req[k] is the request of the requester k+1 places after the last winner
    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_rot
        assign rot_req[gi] = req[2'(last_q + 2'(gi + 1))];
    end

    always_comb begin
        offset = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (rot_req[k]) begin
                offset = 2'(k);
            end
        end
        winner = last_q + offset + 2'd1;
    end

`ifdef MUXARB_TIMEOUT_EN
    assign timeout = (hold_cnt_q == 8'(MAX_HOLD));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;
        data_out_d = (state_q == GRANT) ? data_in[sel_q] : 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d    = GRANT;
                    sel_d      = winner;
                    gnt_d      = 4'b0001 << winner;
                    last_d     = winner;
                    hold_cnt_d = 8'd1;
                end else begin
                    gnt_d = 4'b0000;
                end
            end
            GRANT: begin
                // release always passes through IDLE, so other requests wait for the next arbitration
                if (timeout || !req[sel_q]) begin
                    state_d = IDLE;
                    gnt_d   = 4'b0000;
                end else if (hold_cnt_q != 8'hFF) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            last_q     <= 2'd3;
            sel_q      <= 2'd0;
            gnt_q      <= 4'b0000;
            hold_cnt_q <= 8'd0;
            data_out_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            sel_q      <= sel_d;
            gnt_q      <= gnt_d;
            hold_cnt_q <= hold_cnt_d;
            data_out_q <= data_out_d;
        end
    end

    assign gnt      = gnt_q;
    assign sel      = sel_q;
    assign busy     = (state_q == GRANT);
    assign data_out = data_out_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed stimulus, grant scoreboard checked by a negedge monitor.
module tb_mux4_rr_arbiter;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] data_in = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       data_out;

    int checks = 0;
    int failures = 0;

    // idx: expected winner; len: expected busy cycles (0 = unchecked); gap: expected idle cycles before (0 = unchecked)
    typedef struct {
        logic [1:0] idx;
        int         len;
        int         gap;
    } exp_t;
    exp_t exp_q[$];

    mux4_rr_arbiter #(.MAX_HOLD(4)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .req      (req),
        .data_in  (data_in),
        .gnt      (gnt),
        .sel      (sel),
        .busy     (busy),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, want);
        end else begin
            $display("ok   %s got=%0h", name, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] idx, input int len, input int gap);
        exp_t e;
        e.idx = idx;
        e.len = len;
        e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        req     = 4'b0000;
        resetn  = 1'b0;
        step();
        step();
        chk("rst_gnt", {4'b0, gnt}, 8'h00);
        chk("rst_sel", {6'b0, sel}, 8'h00);
        chk("rst_busy", {7'b0, busy}, 8'h00);
        chk("rst_dout", {7'b0, data_out}, 8'h00);
        resetn = 1'b1;
    endtask

    // Monitor: pops one expectation at each grant start, checks run length at grant end
    initial begin : monitor
        logic prev_active;
        int   run_len;
        int   gap;
        exp_t cur;
        bit   have_cur;
        logic [3:0] oh;
        prev_active = 1'b0;
        run_len = 0;
        gap = 0;
        have_cur = 1'b0;
        forever begin
            @(negedge clk);
            if (gnt != 4'b0000 && !prev_active) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_grant got gnt=%b exp=none", gnt);
                    have_cur = 1'b0;
                end else begin
                    cur = exp_q.pop_front();
                    have_cur = 1'b1;
                    oh = 4'b0001 << cur.idx;
                    chk("grant_sel", {6'b0, sel}, {6'b0, cur.idx});
                    chk("grant_gnt", {4'b0, gnt}, {4'b0, oh});
                    chk("grant_busy", {7'b0, busy}, 8'h01);
                    if (cur.gap != 0) chk("idle_gap", 8'(gap), 8'(cur.gap));
                end
                run_len = 1;
            end else if (gnt != 4'b0000) begin
                run_len++;
            end else if (prev_active) begin
                if (have_cur && cur.len != 0) chk("grant_len", 8'(run_len), 8'(cur.len));
                have_cur = 1'b0;
                gap = 1;
            end else begin
                gap++;
            end
            prev_active = (gnt != 4'b0000);
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench timed out");
    end

    initial begin : stimulus
        logic [3:0] oh;
        // reset then single request
        do_reset();
        req = 4'b0100;
        data_in = 4'b0100;
        push(2'd2, 2, 0);
        step();
        chk("single_gnt", {4'b0, gnt}, 8'h04);
        chk("single_sel", {6'b0, sel}, 8'h02);
        chk("single_busy", {7'b0, busy}, 8'h01);
        step();
        chk("single_dout", {7'b0, data_out}, 8'h01);
        req = 4'b0000;
        step();
        chk("release_busy", {7'b0, busy}, 8'h00);
        chk("release_gnt", {4'b0, gnt}, 8'h00);
        step();
        chk("release_dout", {7'b0, data_out}, 8'h00);

        // all four requesting, each releasing after two grant cycles
        do_reset();
        push(2'd0, 2, 0);
        push(2'd1, 2, 1);
        push(2'd2, 2, 1);
        push(2'd3, 2, 1);
        push(2'd0, 2, 1);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            step();
            oh = 4'b0001 << (k % 4);
            req = 4'b1111 & ~oh;
            step();
            req = (k == 4) ? 4'b0000 : 4'b1111;
        end
        step();

        // mux routing
        for (int i = 0; i < 4; i++) begin
            oh = 4'b0001 << i;
            data_in = oh;
            req = oh;
            push(2'(i), 3, 0);
            step();
            step();
            chk($sformatf("route%0d_one", i), {7'b0, data_out}, 8'h01);
            data_in = ~oh;
            step();
            chk($sformatf("route%0d_zero", i), {7'b0, data_out}, 8'h00);
            req = 4'b0000;
            step();
            step();
            chk($sformatf("route%0d_idle", i), {7'b0, data_out}, 8'h00);
        end

        // asynchronous reset while requester 3 is granted
        data_in = 4'b1000;
        req = 4'b1000;
        push(2'd3, 0, 0);
        step();
        step();
        chk("pre_rst_dout", {7'b0, data_out}, 8'h01);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_gnt", {4'b0, gnt}, 8'h00);
        chk("async_sel", {6'b0, sel}, 8'h00);
        chk("async_busy", {7'b0, busy}, 8'h00);
        chk("async_dout", {7'b0, data_out}, 8'h00);
        req = 4'b1001;
        resetn = 1'b1;
        push(2'd0, 1, 0);
        step();
        req = 4'b0000;
        step();
        step();

        // long hold with two requesters
        do_reset();
`ifdef MUXARB_TIMEOUT_EN
        push(2'd0, 4, 0);
        push(2'd1, 4, 1);
        push(2'd0, 1, 1);
        req = 4'b0011;
        for (int n = 0; n < 11; n++) step();
        req = 4'b0000;
        step();
        step();
`else
        push(2'd0, 51, 0);
        req = 4'b0011;
        step();
        for (int n = 0; n < 50; n++) step();
        chk("hold50_gnt", {4'b0, gnt}, 8'h01);
        req = 4'b0000;
        step();
        step();
`endif

        // requests raised and dropped mid-grant are ignored
        do_reset();
        push(2'd1, 5, 0);
        push(2'd2, 0, 1);
        req = 4'b0010;
        step();
        step();
        req = 4'b0011;
        step();
        step();
        req = 4'b0010;
        step();
        req = 4'b0100;
        step();
        step();
        req = 4'b0000;
        step();
        step();
        step();

        chk("scoreboard_empty", 8'(exp_q.size()), 8'h00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
